// File: rtl/sim_mem_preload_ctrl_if.sv
// Bus bundle for the preload controller: loader stream, core memory port and
// the single SRAM port. The controller uses the slave view; the surrounding
// environment (loader, core, SRAM) uses the master view.
interface sim_mem_preload_ctrl_if #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdxW      = 25
);
  // ELF preload stream
  logic                 load_valid;
  logic                 load_ready;
  logic [AddrWidth-1:0] load_addr;
  logic [63:0]          load_data;
  logic                 load_last;

  // Core request/response port
  logic                 core_req;
  logic                 core_we;
  logic [AddrWidth-1:0] core_addr;
  logic [63:0]          core_wdata;
  logic [7:0]           core_be;
  logic                 core_gnt;
  logic                 core_rvalid;
  logic [63:0]          core_rdata;

  // Single SRAM port, word addressed, 1-cycle read latency
  logic                 sram_req;
  logic                 sram_we;
  logic [IdxW-1:0]      sram_addr;
  logic [63:0]          sram_wdata;
  logic [7:0]           sram_be;
  logic [63:0]          sram_rdata;

  modport slave (
    input  load_valid, load_addr, load_data, load_last,
    output load_ready,
    input  core_req, core_we, core_addr, core_wdata, core_be,
    output core_gnt, core_rvalid, core_rdata,
    output sram_req, sram_we, sram_addr, sram_wdata, sram_be,
    input  sram_rdata
  );

  modport master (
    output load_valid, load_addr, load_data, load_last,
    input  load_ready,
    output core_req, core_we, core_addr, core_wdata, core_be,
    input  core_gnt, core_rvalid, core_rdata,
    input  sram_req, sram_we, sram_addr, sram_wdata, sram_be,
    output sram_rdata
  );
endinterface

// File: rtl/sim_mem_preload_ctrl.sv
// Simulation bring-up memory controller. Owns the SRAM port: first streams an
// ELF image into SRAM with the core held in reset, then releases the core and
// forwards its requests. Watches tohost writes and a RUN-cycle watchdog to
// report the end of simulation on exit_o.
module sim_mem_preload_ctrl #(
  parameter int unsigned NumWords    = 2**25,
  parameter int unsigned AddrWidth   = 64,
  parameter logic [63:0] TohostAddr  = 64'h8000_1000,
  parameter logic [30:0] TimeoutCode = 31'h7FFF_FFFF,
  localparam int unsigned IdxW       = $clog2(NumWords)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         preload_en_i,
  input  logic [63:0]                  max_cycles_i,
  sim_mem_preload_ctrl_if.slave        bus,
  output logic                         core_rst_no,
  output logic [31:0]                  exit_o,
  output logic                         timeout_o
);

  // Word index of tohost; addresses are compared on the index so any byte
  // offset inside the word and any aliasing upper bits still hit.
  localparam logic [IdxW-1:0] TohostIdx = TohostAddr[IdxW+2:3];

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRelease,
    StRun,
    StDone
  } state_e;

  state_e          state;
  state_e          next_state;

  logic [63:0]     cycle_count;
  logic            rvalid_q;
  logic            core_rst_q;
  logic            timeout_q;
  logic [31:0]     exit_q;

  logic            in_load;
  logic            in_run;
  logic            core_active;
  logic            load_fire;
  logic            core_fire;
  logic            tohost_hit;
  logic            wdog_expire;
  logic [IdxW-1:0] load_idx;
  logic [IdxW-1:0] core_idx;
  logic            unused_addr_bits;

  assign load_idx    = bus.load_addr[IdxW+2:3];
  assign core_idx    = bus.core_addr[IdxW+2:3];

  // Only the word-index bits of the byte addresses matter; the rest are
  // folded here so they are visibly consumed.
  assign unused_addr_bits = ^{bus.load_addr, bus.core_addr};

  assign in_load     = (state == StLoad);
  assign in_run      = (state == StRun);
  assign core_active = (state == StRun) || (state == StDone);
  assign load_fire   = in_load && bus.load_valid;
  assign core_fire   = core_active && bus.core_req;

  // Tohost is only recognised while running; once DONE the exit code is frozen.
  assign tohost_hit  = in_run && core_fire && bus.core_we &&
                       (core_idx == TohostIdx) &&
                       bus.core_be[0] && bus.core_wdata[0];

  assign wdog_expire = in_run && (max_cycles_i != 64'd0) &&
                       (cycle_count == max_cycles_i);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= StIdle;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: IDLE is a single cycle, LOAD ends on the last beat,
  // RELEASE is one quiet SRAM cycle, RUN ends on tohost or watchdog.
  always_comb begin
    next_state = state;
    unique case (state)
      StIdle: begin
        next_state = preload_en_i ? StLoad : StRelease;
      end
      StLoad: begin
        if (load_fire && bus.load_last) begin
          next_state = StRelease;
        end
      end
      StRelease: begin
        next_state = StRun;
      end
      StRun: begin
        if (tohost_hit || wdog_expire) begin
          next_state = StDone;
        end
      end
      StDone: begin
        next_state = StDone;
      end
      default: begin
        next_state = StIdle;
      end
    endcase
  end

  // Output logic: SRAM port mux (loader in LOAD, core in RUN/DONE) and the
  // same-cycle handshakes. The bus is held at zero whenever nobody owns it.
  always_comb begin
    bus.load_ready = 1'b0;
    bus.core_gnt   = 1'b0;
    bus.sram_req   = 1'b0;
    bus.sram_we    = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    bus.sram_be    = '0;
    unique case (state)
      StLoad: begin
        bus.load_ready = 1'b1;
        if (bus.load_valid) begin
          bus.sram_req   = 1'b1;
          bus.sram_we    = 1'b1;
          bus.sram_addr  = load_idx;
          bus.sram_wdata = bus.load_data;
          bus.sram_be    = 8'hFF;
        end
      end
      StRun, StDone: begin
        bus.core_gnt = bus.core_req;
        if (bus.core_req) begin
          bus.sram_req   = 1'b1;
          bus.sram_we    = bus.core_we;
          bus.sram_addr  = core_idx;
          bus.sram_wdata = bus.core_wdata;
          bus.sram_be    = bus.core_be;
        end
      end
      default: begin
      end
    endcase
  end

  // Core reset is released on the edge that enters RUN and stays released.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      core_rst_q <= 1'b0;
    end else if (state == StRelease) begin
      core_rst_q <= 1'b1;
    end
  end

  // Every grant, read or write, gets a response one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= core_fire;
    end
  end

  // Watchdog counter: counts RUN cycles only and saturates instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_count <= '0;
    end else if (in_run && (cycle_count != '1)) begin
      cycle_count <= cycle_count + 64'd1;
    end
  end

  // Exit reporting: tohost has priority over a simultaneous watchdog expiry,
  // and both triggers are gated to RUN so the result is sticky.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exit_q    <= '0;
      timeout_q <= 1'b0;
    end else if (tohost_hit) begin
      exit_q    <= bus.core_wdata[31:0];
    end else if (wdog_expire) begin
      exit_q    <= {TimeoutCode, 1'b1};
      timeout_q <= 1'b1;
    end
  end

  assign bus.core_rvalid = rvalid_q;
  assign bus.core_rdata  = rvalid_q ? bus.sram_rdata : '0;
  assign core_rst_no     = core_rst_q;
  assign exit_o          = exit_q;
  assign timeout_o       = timeout_q;

endmodule
